// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared definitions for the pipeline hazard controller. It holds
//               the controller state encoding and the default widths of
//               register specifiers and performance counters.
// Ports       : none (package)
// Revision    : 1.0  initial release
// ============================================================================
package pipe_ctrl_pkg;

    // Default width of a register specifier (64 architectural registers).
    localparam int c_REG_ADDR_W = 6;

    // Default width of each saturating performance counter.
    localparam int c_CNT_W = 16;

    // Controller states. The encoding is explicit so that the state register
    // width is fixed and does not depend on the tool.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl_if
// Description : Bundle between the pipeline datapath and the hazard
//               controller. The datapath side (master) supplies stage
//               information and the branch resolution, and it consumes the
//               load enables, squash requests and counter values. The
//               controller side (slave) does the reverse.
// Signals     : id_rs/id_rt/id_uses_rs/id_uses_rt : ID-stage sources
//               ex_regWrt/ex_rd, wb_regWrt/wb_rd   : in-flight producers
//               branchControl                      : taken branch in WB
//               ctr_clear                          : clear both counters
//               pc_write/ifid_write/idex_bubble    : stall controls
//               ifid_flush/idex_flush/exwb_flush   : squash controls
//               stall_cycles/flush_events          : performance counters
// Revision    : 1.0  initial release
// ============================================================================
interface pipeline_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 6,
    parameter int CNT_W      = 16
);

    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rs;
    logic                  id_uses_rt;
    logic                  ex_regWrt;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  wb_regWrt;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic                  branchControl;
    logic                  ctr_clear;

    logic                  pc_write;
    logic                  ifid_write;
    logic                  idex_bubble;
    logic                  ifid_flush;
    logic                  idex_flush;
    logic                  exwb_flush;
    logic [CNT_W-1:0]      stall_cycles;
    logic [CNT_W-1:0]      flush_events;

    // Pipeline datapath side.
    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt,
        output ex_regWrt, ex_rd, wb_regWrt, wb_rd,
        output branchControl, ctr_clear,
        input  pc_write, ifid_write, idex_bubble,
        input  ifid_flush, idex_flush, exwb_flush,
        input  stall_cycles, flush_events
    );

    // Hazard controller side.
    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt,
        input  ex_regWrt, ex_rd, wb_regWrt, wb_rd,
        input  branchControl, ctr_clear,
        output pc_write, ifid_write, idex_bubble,
        output ifid_flush, idex_flush, exwb_flush,
        output stall_cycles, flush_events
    );

endinterface : pipeline_hazard_ctrl_if
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones instead of wrapping. A
//               clear takes priority over an increment in the same cycle.
// Ports       : clock  - rising-edge clock
//               reset  - synchronous active-high reset (count -> 0)
//               clear  - synchronous clear (count -> 0)
//               inc    - add one this cycle unless saturated
//               count  - current value
// Revision    : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             clear,
    input  wire logic             inc,
    output logic      [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;
    logic             w_at_max;

    assign w_at_max = &r_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (inc && !w_at_max) begin
            r_count <= r_count + c_ONE;
        end
    end

    assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Stall/flush controller for the pipeline. It detects read-
//               after-write hazards between the ID instruction and producers
//               in EX or WB. On a hazard it freezes PC and IF/ID and injects a
//               bubble into ID/EX. A taken branch resolved in WB squashes
//               IF/ID, ID/EX and EX/WB. The module also counts stall cycles
//               and flush events.
// Ports       : clock - rising-edge clock
//               reset - synchronous active-high reset
//               hz    - controller side of pipeline_hazard_ctrl_if
// Revision    : 1.0  initial release
// ============================================================================
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = c_REG_ADDR_W,
    parameter int CNT_W      = c_CNT_W
) (
    input  wire logic              clock,
    input  wire logic              reset,
    pipeline_hazard_ctrl_if.slave  hz
);

    state_t r_state;
    state_t w_next_state;

    logic w_rs_hit;
    logic w_rt_hit;
    logic w_hazard;

    logic w_pc_write;
    logic w_ifid_write;
    logic w_idex_bubble;
    logic w_flush;

    // ------------------------------------------------------------------------
    // Hazard detection. The register file is written on the edge that ends
    // WB, so a WB producer is still invisible to an ID read in the same cycle
    // and must be waited on. Register 0 is an ordinary register here.
    // ------------------------------------------------------------------------
    assign w_rs_hit = hz.id_uses_rs &&
                      ((hz.ex_regWrt && (hz.id_rs == hz.ex_rd)) ||
                       (hz.wb_regWrt && (hz.id_rs == hz.wb_rd)));

    assign w_rt_hit = hz.id_uses_rt &&
                      ((hz.ex_regWrt && (hz.id_rt == hz.ex_rd)) ||
                       (hz.wb_regWrt && (hz.id_rt == hz.wb_rd)));

    assign w_hazard = w_rs_hit || w_rt_hit;

    // ------------------------------------------------------------------------
    // State register.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and outputs. The enables depend combinationally on the
    // current inputs so the pipeline reacts in the same cycle. Reset comes
    // first, then the branch squash, which overrides any stall.
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state  = r_state;
        w_pc_write    = 1'b1;
        w_ifid_write  = 1'b1;
        w_idex_bubble = 1'b0;
        w_flush       = 1'b0;

        if (reset) begin
            // Hold the front end and keep ID/EX empty while in reset.
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_bubble = 1'b1;
            w_next_state  = ST_RUN;
        end else if (hz.branchControl) begin
            w_flush      = 1'b1;
            w_next_state = ST_FLUSH;
        end else begin
            case (r_state)
                ST_FLUSH: begin
                    // ID holds a squashed slot, so its specifiers are ignored.
                    w_next_state = ST_RUN;
                end
                ST_RUN, ST_STALL: begin
                    if (w_hazard) begin
                        w_pc_write    = 1'b0;
                        w_ifid_write  = 1'b0;
                        w_idex_bubble = 1'b1;
                        w_next_state  = ST_STALL;
                    end else begin
                        w_next_state  = ST_RUN;
                    end
                end
                default: begin
                    w_next_state = ST_RUN;
                end
            endcase
        end
    end

    assign hz.pc_write    = w_pc_write;
    assign hz.ifid_write  = w_ifid_write;
    assign hz.idex_bubble = w_idex_bubble;
    assign hz.ifid_flush  = w_flush;
    assign hz.idex_flush  = w_flush;
    assign hz.exwb_flush  = w_flush;

    // ------------------------------------------------------------------------
    // Performance counters.
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] w_stall_cycles;
    logic [CNT_W-1:0] w_flush_events;

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_ctr (
        .clock (clock),
        .reset (reset),
        .clear (hz.ctr_clear),
        .inc   (~w_pc_write),
        .count (w_stall_cycles)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_flush_ctr (
        .clock (clock),
        .reset (reset),
        .clear (hz.ctr_clear),
        .inc   (hz.branchControl),
        .count (w_flush_events)
    );

    assign hz.stall_cycles = w_stall_cycles;
    assign hz.flush_events = w_flush_events;

endmodule : pipeline_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Directed bench for pipeline_hazard_ctrl. A driver applies one
//               input vector per cycle and queues the hand-computed outputs
//               for that cycle. A monitor on the falling edge pops each
//               queued entry and compares it with the DUT.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    logic clk;
    logic rst;

    pipeline_hazard_ctrl_if #(.REG_ADDR_W(6), .CNT_W(16)) bus ();

    pipeline_hazard_ctrl #(
        .REG_ADDR_W (6),
        .CNT_W      (16)
    ) dut (
        .clock (clk),
        .reset (rst),
        .hz    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        pc;
        logic        ifid;
        logic        bub;
        logic [2:0]  fl;
        logic [15:0] sc;
        logic [15:0] fe;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Applies one input vector right after the rising edge.
    task automatic drive(input logic r, input logic [5:0] rs, input logic [5:0] rt,
                         input logic urs, input logic urt,
                         input logic exw, input logic [5:0] exrd,
                         input logic wbw, input logic [5:0] wbrd,
                         input logic br, input logic clr);
        @(posedge clk);
        #1;
        rst                = r;
        bus.id_rs          = rs;
        bus.id_rt          = rt;
        bus.id_uses_rs     = urs;
        bus.id_uses_rt     = urt;
        bus.ex_regWrt      = exw;
        bus.ex_rd          = exrd;
        bus.wb_regWrt      = wbw;
        bus.wb_rd          = wbrd;
        bus.branchControl  = br;
        bus.ctr_clear      = clr;
    endtask

    // Queues the outputs expected for the vector just applied.
    task automatic expect_out(input string tag, input logic pc, input logic ifid,
                              input logic bub, input logic fl,
                              input logic [15:0] sc, input logic [15:0] fe);
        exp_t e;
        e.tag  = tag;
        e.pc   = pc;
        e.ifid = ifid;
        e.bub  = bub;
        e.fl   = {fl, fl, fl};
        e.sc   = sc;
        e.fe   = fe;
        q.push_back(e);
    endtask

    // Monitor: compare on the falling edge, away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_cmp++;
                if (bus.pc_write !== e.pc || bus.ifid_write !== e.ifid ||
                    bus.idex_bubble !== e.bub ||
                    {bus.ifid_flush, bus.idex_flush, bus.exwb_flush} !== e.fl ||
                    bus.stall_cycles !== e.sc || bus.flush_events !== e.fe) begin
                    n_bad++;
                    $display("FAIL %s: got pc=%b ifid=%b bub=%b fl=%b sc=%h fe=%h, expected pc=%b ifid=%b bub=%b fl=%b sc=%h fe=%h",
                             e.tag, bus.pc_write, bus.ifid_write, bus.idex_bubble,
                             {bus.ifid_flush, bus.idex_flush, bus.exwb_flush},
                             bus.stall_cycles, bus.flush_events,
                             e.pc, e.ifid, e.bub, e.fl, e.sc, e.fe);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst               = 1'b1;
        bus.id_rs         = '0;
        bus.id_rt         = '0;
        bus.id_uses_rs    = 1'b0;
        bus.id_uses_rt    = 1'b0;
        bus.ex_regWrt     = 1'b0;
        bus.ex_rd         = '0;
        bus.wb_regWrt     = 1'b0;
        bus.wb_rd         = '0;
        bus.branchControl = 1'b0;
        bus.ctr_clear     = 1'b0;

        //     r  rs  rt  urs urt exw exrd wbw wbrd br clr
        drive(1, 0,  0,  0,  0,  0,  0,   0,  0,   0, 0); expect_out("reset0",      0,0,1,0, 16'd0, 16'd0);
        drive(1, 5,  0,  1,  0,  1,  5,   0,  0,   1, 0); expect_out("reset1",      0,0,1,0, 16'd0, 16'd0);
        drive(0, 0,  0,  0,  0,  0,  0,   0,  0,   0, 0); expect_out("run_idle",    1,1,0,0, 16'd0, 16'd0);
        // EX producer of r5, then it moves to WB: two stall cycles.
        drive(0, 5,  0,  1,  0,  1,  5,   0,  0,   0, 0); expect_out("ex_haz",      0,0,1,0, 16'd0, 16'd0);
        drive(0, 5,  0,  1,  0,  0,  0,   1,  5,   0, 0); expect_out("wb_haz",      0,0,1,0, 16'd1, 16'd0);
        drive(0, 5,  0,  1,  0,  0,  0,   0,  0,   0, 0); expect_out("stall_exit",  1,1,0,0, 16'd2, 16'd0);
        // WB-only producer on rt: one stall cycle.
        drive(0, 0,  7,  0,  1,  0,  0,   1,  7,   0, 0); expect_out("wb_rt_haz",   0,0,1,0, 16'd2, 16'd0);
        drive(0, 0,  7,  0,  1,  0,  0,   0,  0,   0, 0); expect_out("wb_rt_exit",  1,1,0,0, 16'd3, 16'd0);
        // Branch together with a hazard: flush wins, FLUSH ignores the hazard.
        drive(0, 5,  0,  1,  0,  1,  5,   0,  0,   1, 0); expect_out("br_haz",      1,1,0,1, 16'd3, 16'd0);
        drive(0, 5,  0,  1,  0,  1,  5,   0,  0,   0, 0); expect_out("flush_nohaz", 1,1,0,0, 16'd3, 16'd1);
        drive(0, 5,  0,  1,  0,  1,  5,   0,  0,   0, 0); expect_out("run_haz",     0,0,1,0, 16'd3, 16'd1);
        // Branch in STALL, then again in FLUSH.
        drive(0, 5,  0,  1,  0,  1,  5,   0,  0,   1, 0); expect_out("br_in_stall", 1,1,0,1, 16'd4, 16'd1);
        drive(0, 5,  0,  1,  0,  1,  5,   0,  0,   1, 0); expect_out("br_in_flush", 1,1,0,1, 16'd4, 16'd2);
        drive(0, 0,  0,  0,  0,  0,  0,   0,  0,   0, 0); expect_out("flush_done",  1,1,0,0, 16'd4, 16'd3);
        // Matching specifiers but no source used: no stall.
        drive(0, 5,  5,  0,  0,  1,  5,   1,  5,   0, 0); expect_out("unused_src",  1,1,0,0, 16'd4, 16'd3);
        // Register 0 is an ordinary register.
        drive(0, 0,  0,  1,  0,  1,  0,   0,  0,   0, 0); expect_out("reg0_haz",    0,0,1,0, 16'd4, 16'd3);
        drive(0, 0,  0,  0,  0,  0,  0,   0,  0,   0, 1); expect_out("clear",       1,1,0,0, 16'd5, 16'd3);
        drive(0, 0,  0,  0,  0,  0,  0,   0,  0,   0, 0); expect_out("cleared",     1,1,0,0, 16'd0, 16'd0);
        // Reset during STALL.
        drive(0, 5,  0,  1,  0,  1,  5,   0,  0,   0, 0); expect_out("pre_rst_st",  0,0,1,0, 16'd0, 16'd0);
        drive(1, 5,  0,  1,  0,  1,  5,   0,  0,   0, 0); expect_out("rst_in_st",   0,0,1,0, 16'd1, 16'd0);
        drive(0, 0,  0,  0,  0,  0,  0,   0,  0,   0, 0); expect_out("post_rst_st", 1,1,0,0, 16'd0, 16'd0);
        // Reset during FLUSH: the first cycle after release is RUN, so a
        // hazard present then must stall.
        drive(0, 0,  0,  0,  0,  0,  0,   0,  0,   1, 0); expect_out("pre_rst_fl",  1,1,0,1, 16'd0, 16'd0);
        drive(1, 5,  0,  1,  0,  1,  5,   0,  0,   0, 0); expect_out("rst_in_fl",   0,0,1,0, 16'd0, 16'd1);
        drive(0, 5,  0,  1,  0,  1,  5,   0,  0,   0, 0); expect_out("post_rst_fl", 0,0,1,0, 16'd0, 16'd0);
        drive(0, 0,  0,  0,  0,  0,  0,   0,  0,   0, 0); expect_out("recover",     1,1,0,0, 16'd1, 16'd0);
        drive(0, 0,  0,  0,  0,  0,  0,   0,  0,   0, 1); expect_out("clear2",      1,1,0,0, 16'd1, 16'd0);

        // Run the stall counter up to 0xFFFE with a persistent hazard.
        for (int i = 0; i < 65534; i++) begin
            drive(0, 5, 0, 1, 0, 1, 5, 0, 0, 0, 0);
        end
        drive(0, 5,  0,  1,  0,  1,  5,   0,  0,   0, 0); expect_out("sat_fffe",    0,0,1,0, 16'hFFFE, 16'd0);
        drive(0, 5,  0,  1,  0,  1,  5,   0,  0,   0, 0); expect_out("sat_ffff",    0,0,1,0, 16'hFFFF, 16'd0);
        drive(0, 5,  0,  1,  0,  1,  5,   0,  0,   0, 0); expect_out("sat_hold",    0,0,1,0, 16'hFFFF, 16'd0);
        drive(0, 5,  0,  1,  0,  1,  5,   0,  0,   0, 1); expect_out("clr_w_stall", 0,0,1,0, 16'hFFFF, 16'd0);
        drive(0, 0,  0,  0,  0,  0,  0,   0,  0,   0, 0); expect_out("clr_prio",    1,1,0,0, 16'd0, 16'd0);

        // Let the monitor drain the queue, within a bounded number of cycles.
        for (int i = 0; i < 5 && q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: got %0d entries left, expected 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_pipeline_hazard_ctrl
`default_nettype wire
